aes_key_expand: RTL and testbench

//   AES-128 key schedule (FIPS-197). Accepts a 128-bit cipher key and streams

---
 rtl/aes_key_expand.sv | 182 ++++++++++++++++++
 tb/tb_aes_key_expand.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: accepts a cipher key and streams round keys 0..10
// with valid/ready flow control; SubWord uses four arithmetic S-boxes.

module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte_c
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  logic [7:0] w_inv;

  always_comb begin
    w_inv    = gf_inv(i_byte);
    o_byte_c = w_inv
             ^ {w_inv[6:0], w_inv[7]}
             ^ {w_inv[5:0], w_inv[7:6]}
             ^ {w_inv[4:0], w_inv[7:5]}
             ^ {w_inv[3:0], w_inv[7:4]}
             ^ 8'h63;
  end

endmodule

module aes_key_expand #(
  parameter int unsigned NR       = 10,
  parameter int unsigned SBOX_REG = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         done
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_CALC = 2'd2
  } state_t;

  state_t       r_state;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_sub_sel;
  logic [31:0]  w_t;
  logic [7:0]   w_rcon;
  logic [31:0]  w_n0;
  logic [31:0]  w_n1;
  logic [31:0]  w_n2;
  logic [31:0]  w_n3;

  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    case (idx)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // RotWord of w3, then SubWord byte by byte.
  assign w_rot = {rk_out[23:0], rk_out[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte   (w_rot[8*g +: 8]),
      .o_byte_c (w_sub[8*g +: 8])
    );
  end

  // Optional pipeline stage on SubWord; it is refreshed every EMIT cycle, so
  // in CALC it holds the value computed from the key still in rk_out.
  if (SBOX_REG != 0) begin : g_sub_reg
    logic [31:0] r_sub;
    always_ff @(posedge clk) begin
      if (rst)                    r_sub <= 32'h0;
      else if (r_state == S_EMIT) r_sub <= w_sub;
    end
    assign w_sub_sel = r_sub;
  end else begin : g_sub_comb
    assign w_sub_sel = w_sub;
  end

  assign w_rcon = rcon_of(rk_idx);
  assign w_t    = w_sub_sel ^ {w_rcon, 24'h0};
  assign w_n0   = rk_out[127:96] ^ w_t;
  assign w_n1   = rk_out[95:64]  ^ w_n0;
  assign w_n2   = rk_out[63:32]  ^ w_n1;
  assign w_n3   = rk_out[31:0]   ^ w_n2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      key_ready <= 1'b1;
      rk_valid  <= 1'b0;
      rk_out    <= 128'h0;
      rk_idx    <= 4'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (key_valid) begin
            rk_out    <= key_in;
            rk_idx    <= 4'd0;
            rk_valid  <= 1'b1;
            key_ready <= 1'b0;
            r_state   <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (rk_ready) begin
            if (rk_idx == LAST_IDX) begin
              rk_valid  <= 1'b0;
              key_ready <= 1'b1;
              done      <= 1'b1;
              r_state   <= S_IDLE;
            end else if (SBOX_REG == 0) begin
              rk_out <= {w_n0, w_n1, w_n2, w_n3};
              rk_idx <= rk_idx + 4'd1;
            end else begin
              rk_valid <= 1'b0;
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rk_out   <= {w_n0, w_n1, w_n2, w_n3};
          rk_idx   <= rk_idx + 4'd1;
          rk_valid <= 1'b1;
          r_state  <= S_EMIT;
        end
        default: begin
          r_state   <= S_IDLE;
          key_ready <= 1'b1;
          rk_valid  <= 1'b0;
        end
      endcase
    end
  end

  a_idx_range: assert property (@(posedge clk) disable iff (rst) rk_idx <= LAST_IDX);

endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: known-answer table, stalls, reset,
// ignored keys and random keys on both the 1-cycle and 2-cycle builds.

module tb_aes_key_expand;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] key_in    [2];
  logic         key_valid [2];
  logic         key_ready [2];
  logic [127:0] rk_out    [2];
  logic [3:0]   rk_idx    [2];
  logic         rk_valid  [2];
  logic         rk_ready  [2];
  logic         done      [2];

  aes_key_expand #(.NR(10), .SBOX_REG(0)) u_dut0 (
    .clk(clk), .rst(rst), .key_in(key_in[0]), .key_valid(key_valid[0]),
    .key_ready(key_ready[0]), .rk_out(rk_out[0]), .rk_idx(rk_idx[0]),
    .rk_valid(rk_valid[0]), .rk_ready(rk_ready[0]), .done(done[0])
  );

  aes_key_expand #(.NR(10), .SBOX_REG(1)) u_dut1 (
    .clk(clk), .rst(rst), .key_in(key_in[1]), .key_valid(key_valid[1]),
    .key_ready(key_ready[1]), .rk_out(rk_out[1]), .rk_idx(rk_idx[1]),
    .rk_valid(rk_valid[1]), .rk_ready(rk_ready[1]), .done(done[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]   sbox_tab [256];
  logic [127:0] exp_rk   [11];
  logic [127:0] got_rk   [11];

  localparam logic [127:0] K1      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  typedef struct {
    logic [127:0] key;
    int           idx;
    logic [127:0] rk;
  } vec_t;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: field arithmetic by shift-and-add, S-box by brute-force inverse search.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 0) begin
      if (y[0]) acc ^= x;
      x = xtime(x);
      y = y >> 1;
    end
    return acc;
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      logic [7:0] c = 8'h63;
      for (int b = 1; b < 256; b++)
        if (fmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[a] = s;
    end
  endtask

  task automatic build_model(input logic [127:0] key);
    logic [31:0] w [44];
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      logic [31:0] t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int n = 0; n < 11; n++) exp_rk[n] = {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endtask

  // Feed one key into DUT sel and consume all round keys, checking order,
  // values, stability under stalls and (when unstalled) exact cycle timing.
  task automatic run_stream(input int sel, input logic [127:0] key, input int stall_pct,
                            input bit hold_other);
    int          step = (sel != 0) ? 2 : 1;
    int          t_acc;
    int          t_done = -1;
    int          n_next = 0;
    int          dones = 0;
    bit          stalled_prev = 1'b0;
    logic [127:0] prev_out = '0;
    logic [3:0]  prev_idx = '0;
    build_model(key);
    check("key_ready_idle", 128'(key_ready[sel]), 128'(1));
    key_in[sel]    = key;
    key_valid[sel] = 1'b1;
    rk_ready[sel]  = 1'b0;
    t_acc = cyc;
    tick();
    if (hold_other) key_in[sel] = ~key;
    else            key_valid[sel] = 1'b0;
    check("key_ready_busy", 128'(key_ready[sel]), 128'(0));
    for (int k = 0; k < 300 && t_done < 0; k++) begin
      int d = cyc - t_acc;
      if (key_ready[sel]) key_valid[sel] = 1'b0;
      if (stalled_prev) begin
        check("stall_valid", 128'(rk_valid[sel]), 128'(1));
        check("stall_rk_out", rk_out[sel], prev_out);
        check("stall_rk_idx", 128'(rk_idx[sel]), 128'(prev_idx));
      end
      if (stall_pct == 0)
        check("rk_valid_timing", 128'(rk_valid[sel]),
              128'(d >= 1 && d <= 1 + 10*step && ((d - 1) % step) == 0));
      if (done[sel]) begin
        dones++;
        t_done = cyc;
        check("key_ready_with_done", 128'(key_ready[sel]), 128'(1));
      end
      rk_ready[sel] = ($urandom_range(99) >= stall_pct);
      if (rk_valid[sel] && rk_ready[sel]) begin
        check("rk_idx_order", 128'(rk_idx[sel]), 128'(n_next));
        if (n_next <= 10) begin
          check("rk_out_model", rk_out[sel], exp_rk[n_next]);
          got_rk[n_next] = rk_out[sel];
        end
        if (stall_pct == 0) check("rk_latency", 128'(d), 128'(1 + step*n_next));
        n_next++;
      end
      stalled_prev = rk_valid[sel] && !rk_ready[sel];
      prev_out = rk_out[sel];
      prev_idx = rk_idx[sel];
      if (t_done < 0) tick();
    end
    check("done_seen", 128'(t_done >= 0), 128'(1));
    check("rk_count", 128'(n_next), 128'(11));
    if (stall_pct == 0) check("done_latency", 128'(t_done - t_acc), 128'(2 + 10*step));
    key_valid[sel] = 1'b0;
    rk_ready[sel]  = 1'b0;
    tick();
    if (done[sel]) dones++;
    check("done_once", 128'(dones), 128'(1));
    check("idle_after_done", 128'(key_ready[sel]), 128'(1));
  endtask

  initial begin
    vec_t vecs [6];
    vecs[0] = '{K1,     0,  K1};
    vecs[1] = '{K1,     1,  128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2] = '{K1,     10, K1_RK10};
    vecs[3] = '{128'h0, 0,  128'h0};
    vecs[4] = '{128'h0, 1,  128'h62636363626363636263636362636363};
    vecs[5] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    build_sbox();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      key_in[s] = '0; key_valid[s] = 1'b0; rk_ready[s] = 1'b0;
    end
    tick(); tick();
    for (int s = 0; s < 2; s++) begin
      check("rst_key_ready", 128'(key_ready[s]), 128'(1));
      check("rst_rk_valid",  128'(rk_valid[s]),  128'(0));
      check("rst_rk_out",    rk_out[s],          128'h0);
      check("rst_rk_idx",    128'(rk_idx[s]),    128'(0));
      check("rst_done",      128'(done[s]),      128'(0));
    end
    rst = 1'b0;
    tick();

    // Known-answer table on both builds.
    for (int s = 0; s < 2; s++)
      for (int v = 0; v < 6; v++) begin
        run_stream(s, vecs[v].key, 0, 1'b0);
        check("kat_table", got_rk[vecs[v].idx], vecs[v].rk);
      end

    // Random consumer stalls.
    for (int s = 0; s < 2; s++) begin
      run_stream(s, K1, 40, 1'b0);
      check("stall_rk10", got_rk[10], K1_RK10);
    end

    // A different key held valid during the stream must be ignored.
    for (int s = 0; s < 2; s++) begin
      run_stream(s, K1, 0, 1'b1);
      check("ignore_key_rk10", got_rk[10], K1_RK10);
    end

    // Reset in the middle of a stream at round key 5.
    begin
      bit found = 1'b0;
      int dcount = 0;
      key_in[0] = {$urandom, $urandom, $urandom, $urandom};
      key_valid[0] = 1'b1;
      tick();
      key_valid[0] = 1'b0;
      rk_ready[0]  = 1'b1;
      for (int k = 0; k < 30 && !found; k++) begin
        if (rk_valid[0] && rk_idx[0] == 4'd5) found = 1'b1;
        else tick();
      end
      check("reach_idx5", 128'(found), 128'(1));
      rst = 1'b1;
      tick();
      rst = 1'b0;
      rk_ready[0] = 1'b0;
      check("midrst_rk_valid",  128'(rk_valid[0]),  128'(0));
      check("midrst_key_ready", 128'(key_ready[0]), 128'(1));
      check("midrst_rk_idx",    128'(rk_idx[0]),    128'(0));
      for (int k = 0; k < 15; k++) begin
        if (done[0]) dcount++;
        tick();
      end
      check("midrst_no_done", 128'(dcount), 128'(0));
      run_stream(0, {$urandom, $urandom, $urandom, $urandom}, 0, 1'b0);
    end

    // Random keys against the reference model.
    for (int i = 0; i < 8; i++)
      run_stream(i % 2, {$urandom, $urandom, $urandom, $urandom}, (i < 4) ? 0 : 30, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
